// File: rtl/ix_sched_pkg.sv
// ix_sched_pkg: shared types and helpers for the ix event-matrix scan scheduler.
//   state_e    - scan FSM states
//   row_t/col_t - coordinate types sized for the default 8x8 matrix
//   flat_idx   - (row, col) -> bit index in the row-major flattened matrix
package ix_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWait,
        StDone
    } state_e;

    localparam int unsigned RowsDef = 8;
    localparam int unsigned ColsDef = 8;
    localparam int unsigned RwDef   = $clog2(RowsDef);
    localparam int unsigned CwDef   = $clog2(ColsDef);

    typedef logic [RwDef-1:0] row_t;
    typedef logic [CwDef-1:0] col_t;

    function automatic int unsigned flat_idx(input int unsigned row, input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/ix_rr_arb2.sv
// ix_rr_arb2: two-way round-robin arbiter.
//   clk, rst_n - clock, asynchronous active-low reset
//   vld_i[1:0] - per-requester request
//   gnt_o[1:0] - one-hot0 grant, combinational from vld_i and the priority register
// On a tie the requester not granted last wins; priority moves only on a grant.
module ix_rr_arb2
    import ix_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] vld_i,
    output logic [1:0] gnt_o
);

    logic prio_q;  // 1: requester 1 wins a tie
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        case (vld_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ix_scan_sched.sv
// ix_scan_sched: owns the ROWS x COLS event-bit matrix and schedules service of set bits.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start_i             - begin one scan pass (sampled only when idle)
//   busy_o / done_o     - FSM not idle / one-cycle end-of-pass pulse
//   wr_vld_i/row/col/val - two write requesters, arbitrated round-robin
//   wr_gnt_o            - one-hot0 grant
//   svc_req_o/row/col   - level service request for the cell under the pointer
//   svc_ack_i           - service acknowledge (only honoured while waiting)
//   err_o               - one-cycle pulse when a request times out
//   ix_o                - matrix contents, bit i*COLS+j
module ix_scan_sched
    import ix_sched_pkg::*;
#(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned TIMEOUT    = 15,
    parameter bit          CLR_ON_ACK = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic [1:0]                 wr_vld_i,
    input  logic [2*$clog2(ROWS)-1:0]  wr_row_i,
    input  logic [2*$clog2(COLS)-1:0]  wr_col_i,
    input  logic [1:0]                 wr_val_i,
    output logic [1:0]                 wr_gnt_o,
    output logic                       svc_req_o,
    output logic [$clog2(ROWS)-1:0]    svc_row_o,
    output logic [$clog2(COLS)-1:0]    svc_col_o,
    input  logic                       svc_ack_i,
    output logic                       err_o,
    output logic [ROWS*COLS-1:0]       ix_o
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned NCell = ROWS * COLS;
    localparam int unsigned IdxW  = $clog2(NCell);
    localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

    localparam logic [RW-1:0]   RowLast = RW'(ROWS - 1);
    localparam logic [CW-1:0]   ColLast = CW'(COLS - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e            state_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [CntW-1:0]   cnt_q;  // WAIT cycles already elapsed without ack
    logic              busy_q;
    logic              done_q;
    logic              svc_req_q;
    logic [NCell-1:0]  ix_q;
    logic [NCell-1:0]  ix_d;

    logic [1:0]        gnt;
    logic              last_cell;
    logic [IdxW-1:0]   cur_idx;
    logic              cur_bit;
    logic [RW-1:0]     row_nxt;
    logic [CW-1:0]     col_nxt;
    logic              ack_hit;
    logic              timeout;

    logic              w_en;
    logic [RW-1:0]     w_row;
    logic [CW-1:0]     w_col;
    logic              w_val;
    int unsigned       w_flat;

    ix_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (wr_vld_i),
        .gnt_o (gnt)
    );

    // Pointer bookkeeping; wrap by explicit compare so non-power-of-two sizes work.
    always_comb begin
        last_cell = (row_q == RowLast) && (col_q == ColLast);
        cur_idx   = IdxW'(flat_idx(32'(row_q), 32'(col_q), COLS));
        cur_bit   = ix_q[cur_idx];
        if (col_q == ColLast) begin
            col_nxt = '0;
            row_nxt = row_q + 1'b1;
        end else begin
            col_nxt = col_q + 1'b1;
            row_nxt = row_q;
        end
    end

    // Ack wins over a timeout landing on the same cycle.
    assign ack_hit = (state_q == StWait) && svc_ack_i;
    assign timeout = (state_q == StWait) && !svc_ack_i && (cnt_q == CntLast);

    // Write path selected by the grant.
    always_comb begin
        w_en   = |gnt;
        w_row  = gnt[1] ? wr_row_i[2*RW-1:RW] : wr_row_i[RW-1:0];
        w_col  = gnt[1] ? wr_col_i[2*CW-1:CW] : wr_col_i[CW-1:0];
        w_val  = gnt[1] ? wr_val_i[1] : wr_val_i[0];
        w_flat = flat_idx(32'(w_row), 32'(w_col), COLS);
    end

    // Clear first, then the granted write, so a write to the acked cell wins.
    always_comb begin
        ix_d = ix_q;
        if (CLR_ON_ACK && ack_hit) begin
            ix_d[cur_idx] = 1'b0;
        end
        if (w_en && (w_flat < NCell)) begin
            ix_d[IdxW'(w_flat)] = w_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ix_q <= '0;
        end else begin
            ix_q <= ix_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            svc_req_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StScan;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StScan: begin
                    if (cur_bit) begin
                        state_q   <= StWait;
                        svc_req_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (last_cell) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        row_q <= row_nxt;
                        col_q <= col_nxt;
                    end
                end
                StWait: begin
                    if (ack_hit || timeout) begin
                        svc_req_q <= 1'b0;
                        if (last_cell) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StScan;
                            row_q   <= row_nxt;
                            col_q   <= col_nxt;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign svc_req_o = svc_req_q;
    assign svc_row_o = row_q;
    assign svc_col_o = col_q;
    assign err_o     = timeout;
    assign wr_gnt_o  = gnt;
    assign ix_o      = ix_q;

    svc_req_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
        (svc_req_q && !svc_ack_i && !err_o) |=> (svc_req_q && $stable(row_q) && $stable(col_q)));

    gnt_onehot0_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

    err_no_ack_a : assert property (@(posedge clk) disable iff (!rst_n) !(err_o && svc_ack_i));

endmodule

// File: tb/tb_ix_scan_sched.sv
module tb_ix_scan_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [1:0]  wr_vld = '0;
    logic [5:0]  wr_row = '0;
    logic [5:0]  wr_col = '0;
    logic [1:0]  wr_val = '0;
    logic [1:0]  wr_gnt;
    logic        svc_req;
    logic [2:0]  svc_row, svc_col;
    logic        svc_ack = 1'b0;
    logic        err;
    logic [63:0] ix;

    int checks = 0;
    int errors = 0;

    ix_scan_sched #(
        .ROWS       (8),
        .COLS       (8),
        .TIMEOUT    (15),
        .CLR_ON_ACK (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .wr_vld_i  (wr_vld),
        .wr_row_i  (wr_row),
        .wr_col_i  (wr_col),
        .wr_val_i  (wr_val),
        .wr_gnt_o  (wr_gnt),
        .svc_req_o (svc_req),
        .svc_row_o (svc_row),
        .svc_col_o (svc_col),
        .svc_ack_i (svc_ack),
        .err_o     (err),
        .ix_o      (ix)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bit_at(input int row, input int col);
        logic [63:0] one;
        one = 64'd1;
        return one << (row * 8 + col);
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        svc_ack = 1'b0;
        wr_vld  = '0;
        wr_row  = '0;
        wr_col  = '0;
        wr_val  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 64'({busy, done, svc_req, err, wr_gnt}), 64'd0);
        chk("rst_ptr", 64'({svc_row, svc_col}), 64'd0);
        chk("rst_ix", ix, 64'd0);
        rst_n = 1'b1;
        tick();
    endtask

    // Single-requester write; grant is expected immediately.
    task automatic wr1(input int r, input int row, input int col, input logic val);
        wr_vld    = '0;
        wr_vld[r] = 1'b1;
        wr_row[r*3 +: 3] = 3'(row);
        wr_col[r*3 +: 3] = 3'(col);
        wr_val[r] = val;
        #1;
        chk($sformatf("wr%0d_gnt", r), 64'(wr_gnt), (r == 0) ? 64'd1 : 64'd2);
        tick();
        wr_vld = '0;
    endtask

    // Start a pass at cycle 0 and follow it to done; ack_delay < 0 means never ack.
    task automatic run_pass(input int ack_delay, input int start_len,
                            output int done_cyc, output int busy_cyc, output int n_req,
                            output int req_len, output int n_err, output int err_cyc,
                            output int req_cyc, output logic [2:0] req_row,
                            output logic [2:0] req_col);
        int   w;
        logic prev_req;
        done_cyc = -1; busy_cyc = 0; n_req = 0; req_len = 0; n_err = 0;
        err_cyc = -1; req_cyc = -1; req_row = '0; req_col = '0; w = 0; prev_req = 1'b0;
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            start = (cyc < start_len);
            if (busy) busy_cyc++;
            if (svc_req) begin
                if (!prev_req) begin
                    n_req++;
                    w = 0;
                    if (req_cyc < 0) begin
                        req_cyc = cyc;
                        req_row = svc_row;
                        req_col = svc_col;
                    end
                end
                req_len++;
                svc_ack = (ack_delay >= 0) && (w == ack_delay);
                w++;
            end else begin
                svc_ack = 1'b0;
            end
            prev_req = svc_req;
            #1;
            if (err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            tick();
        end
        start   = 1'b0;
        svc_ack = 1'b0;
    endtask

    initial begin
        int dc, bc, nr, rl, ne, ec, rc, cnt;
        logic [2:0] rr, rcl;

        do_reset();

        // Empty matrix; start held for 10 cycles to show it is ignored once busy.
        run_pass(-1, 10, dc, bc, nr, rl, ne, ec, rc, rr, rcl);
        chki("empty_done_cyc", dc, 65);
        chki("empty_busy_cycles", bc, 65);
        chki("empty_no_req", nr, 0);
        chki("empty_no_err", ne, 0);
        chk("empty_idle_after", 64'(busy), 64'd0);

        // Both requesters valid for 4 cycles: grants alternate from requester 0.
        wr_vld = 2'b11;
        wr_val = 2'b11;
        wr_row = {3'd3, 3'd1};
        wr_col = {3'd3, 3'd1};
        #1 chk("rr_gnt0", 64'(wr_gnt), 64'd1);
        tick();
        chk("rr_ix0", ix, bit_at(1, 1));
        wr_col[2:0] = 3'd2;
        #1 chk("rr_gnt1", 64'(wr_gnt), 64'd2);
        tick();
        chk("rr_ix1", ix, bit_at(1, 1) | bit_at(3, 3));
        wr_col[5:3] = 3'd4;
        #1 chk("rr_gnt2", 64'(wr_gnt), 64'd1);
        tick();
        #1 chk("rr_gnt3", 64'(wr_gnt), 64'd2);
        tick();
        wr_vld = '0;
        chk("rr_ix_all", ix, bit_at(1, 1) | bit_at(1, 2) | bit_at(3, 3) | bit_at(3, 4));

        do_reset();

        // (2,5) set by requester 0, acked 3 cycles after the request rises.
        wr1(0, 2, 5, 1'b1);
        chk("w25_ix", ix, bit_at(2, 5));
        run_pass(3, 1, dc, bc, nr, rl, ne, ec, rc, rr, rcl);
        chki("w25_req_cyc", rc, 23);
        chk("w25_req_rc", 64'({rr, rcl}), 64'({3'd2, 3'd5}));
        chki("w25_req_len", rl, 4);
        chki("w25_no_err", ne, 0);
        chki("w25_done_cyc", dc, 69);
        chk("w25_ix_clear", ix, 64'd0);

        // (7,7) never acked: timeout after 15 request cycles, bit kept.
        wr1(1, 7, 7, 1'b1);
        run_pass(-1, 1, dc, bc, nr, rl, ne, ec, rc, rr, rcl);
        chki("to_req_cyc", rc, 65);
        chki("to_req_len", rl, 15);
        chki("to_err_cnt", ne, 1);
        chki("to_err_cyc", ec, 79);
        chki("to_done_cyc", dc, 80);
        chk("to_ix_kept", ix, bit_at(7, 7));

        // Ack on the very cycle the counter would time out: counts as ack.
        run_pass(14, 1, dc, bc, nr, rl, ne, ec, rc, rr, rcl);
        chki("tob_req_len", rl, 15);
        chki("tob_no_err", ne, 0);
        chki("tob_done_cyc", dc, 80);
        chk("tob_ix_clear", ix, 64'd0);

        // WAIT on (0,0): write (0,1) ahead of pointer, rewrite (0,0) on the ack cycle.
        wr1(0, 0, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("col_req00", 64'({svc_req, svc_row, svc_col}), 64'({1'b1, 3'd0, 3'd0}));
        wr_vld = 2'b01;
        wr_row = 6'd0;
        wr_col = {3'd0, 3'd1};
        wr_val = 2'b01;
        #1 chk("col_gnt_ahead", 64'(wr_gnt), 64'd1);
        tick();
        wr_vld  = 2'b10;
        wr_col  = 6'd0;
        wr_val  = 2'b10;
        svc_ack = 1'b1;
        #1;
        chk("col_gnt_ack", 64'(wr_gnt), 64'd2);
        chk("col_err_ack", 64'(err), 64'd0);
        tick();
        wr_vld  = '0;
        svc_ack = 1'b0;
        chk("col_write_wins", ix, bit_at(0, 0) | bit_at(0, 1));
        chk("col_req_drop", 64'(svc_req), 64'd0);
        tick();
        chk("col_req01", 64'({svc_req, svc_row, svc_col}), 64'({1'b1, 3'd0, 3'd1}));
        svc_ack = 1'b1;
        tick();
        svc_ack = 1'b0;
        chk("col_ix_after", ix, bit_at(0, 0));
        dc = -1;
        for (int c = 6; c <= 200 && dc < 0; c++) begin
            if (done) dc = c;
            else tick();
        end
        chki("col_done_cyc", dc, 68);
        tick();

        // Reset mid-WAIT on (0,0).
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rstw_in_wait", 64'({svc_req, busy}), 64'({1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("rstw_async", 64'({svc_req, busy, done}), 64'd0);
        chk("rstw_ix", ix, 64'd0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done || busy) cnt++;
        end
        chki("rstw_no_done", cnt, 0);
        rst_n = 1'b1;
        tick();
        wr1(0, 0, 0, 1'b1);
        run_pass(0, 1, dc, bc, nr, rl, ne, ec, rc, rr, rcl);
        chki("rstw_req_cyc", rc, 2);
        chk("rstw_req_rc", 64'({rr, rcl}), 64'd0);
        chki("rstw_done_cyc", dc, 66);
        chk("rstw_ix_clear", ix, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
